// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch stage and its neighbours.
package fetch_pkg;

    // Default widths; instruction width matches the decoder.
    localparam int PC_WIDTH_DEF    = 10;
    localparam int INSTR_WIDTH_DEF = 9;
    localparam int CNT_WIDTH_DEF   = 16;

    // Fetch stage sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/fetch_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 inc,
    output logic [cnt_width-1:0] count
);

    logic [cnt_width-1:0] count_r;
    logic [cnt_width-1:0] count_nxt_s;

    // Next count: clear, else increment until all-ones, else hold.
    always_comb begin
        count_nxt_s = count_r;
        if (clear) begin
            count_nxt_s = {cnt_width{1'b0}};
        end else if (inc && (count_r != {cnt_width{1'b1}})) begin
            count_nxt_s = count_r + {{(cnt_width-1){1'b0}}, 1'b1};
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {cnt_width{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count = count_r;

endmodule : sat_counter

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a synchronous ROM and
// presents one instruction per cycle to the decoder, with redirect/halt
// feedback and retired/cycle performance counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int pc_width    = PC_WIDTH_DEF,
    parameter int instr_width = INSTR_WIDTH_DEF,
    parameter int cnt_width   = CNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [pc_width-1:0]    start_addr,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [pc_width-1:0]    redirect_pc,
    input  logic                   halt,
    output logic [pc_width-1:0]    imem_addr,
    output logic                   imem_en,
    input  logic [instr_width-1:0] imem_data,
    output logic [instr_width-1:0] instruction,
    output logic [pc_width-1:0]    instr_pc,
    output logic                   instr_valid,
    output logic                   done,
    output logic [cnt_width-1:0]   instr_count,
    output logic [cnt_width-1:0]   cycle_count
);

    fetch_state_t        state_r;
    fetch_state_t        state_nxt_s;
    logic [pc_width-1:0] fetch_pc_r;
    logic [pc_width-1:0] fetch_pc_nxt_s;
    logic [pc_width-1:0] instr_pc_r;
    logic [pc_width-1:0] instr_pc_nxt_s;
    logic                valid_r;
    logic                valid_nxt_s;
    logic                run_s;
    logic                instr_valid_s;
    logic                accept_s;
    logic                start_go_s;

    assign run_s         = (state_r == RUN);
    assign instr_valid_s = valid_r && run_s;
    assign accept_s      = instr_valid_s && !stall;

    // Next-state, next-PC and presentation-register logic.
    always_comb begin
        state_nxt_s    = state_r;
        fetch_pc_nxt_s = fetch_pc_r;
        instr_pc_nxt_s = instr_pc_r;
        valid_nxt_s    = valid_r;
        start_go_s     = 1'b0;
        case (state_r)
            IDLE, HALTED: begin
                valid_nxt_s = 1'b0;
                if (start) begin
                    state_nxt_s    = RUN;
                    fetch_pc_nxt_s = start_addr;
                    start_go_s     = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            RUN: begin
                if (stall) begin
                    // Frozen: every register holds, nothing is accepted.
                    state_nxt_s = RUN;
                end else begin
                    // A redirect or halt squashes the fetch already in flight.
                    valid_nxt_s    = !(accept_s && (redirect || halt));
                    instr_pc_nxt_s = fetch_pc_r;
                    if (accept_s && redirect && !halt) begin
                        fetch_pc_nxt_s = redirect_pc;
                    end else begin
                        fetch_pc_nxt_s = fetch_pc_r + {{(pc_width-1){1'b0}}, 1'b1};
                    end
                    if (accept_s && halt) begin
                        state_nxt_s = HALTED;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
            end
            default: begin
                state_nxt_s = IDLE;
                valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State, PC and presentation registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            fetch_pc_r <= {pc_width{1'b0}};
            instr_pc_r <= {pc_width{1'b0}};
            valid_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            fetch_pc_r <= fetch_pc_nxt_s;
            instr_pc_r <= instr_pc_nxt_s;
            valid_r    <= valid_nxt_s;
        end
    end

    sat_counter #(.cnt_width(cnt_width)) u_instr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_go_s),
        .inc   (accept_s),
        .count (instr_count)
    );

    sat_counter #(.cnt_width(cnt_width)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_go_s),
        .inc   (run_s),
        .count (cycle_count)
    );

    assign imem_addr   = fetch_pc_r;
    assign imem_en     = run_s && !stall;
    assign instruction = imem_data;
    assign instr_pc    = instr_pc_r;
    assign instr_valid = instr_valid_s;
    assign done        = (state_r == HALTED);

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a behavioural ROM M[i]=i[8:0].
module tb_fetch_unit;

    localparam int PW = 10;
    localparam int IW = 9;
    localparam int CW = 6;   // narrow counters so saturation is reachable
    localparam int NV = 21;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [PW-1:0] start_addr;
    logic          stall;
    logic          redirect;
    logic [PW-1:0] redirect_pc;
    logic          halt;
    logic [PW-1:0] imem_addr;
    logic          imem_en;
    logic [IW-1:0] imem_data = '0;
    logic [IW-1:0] instruction;
    logic [PW-1:0] instr_pc;
    logic          instr_valid;
    logic          done;
    logic [CW-1:0] instr_count;
    logic [CW-1:0] cycle_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic          st;
        logic [PW-1:0] sa;
        logic          stl;
        logic          rd;
        logic [PW-1:0] rpc;
        logic          hl;
        logic          e_valid;
        logic [IW-1:0] e_instr;
        logic [PW-1:0] e_pc;
        logic          e_en;
        logic          chk_addr;
        logic [PW-1:0] e_addr;
        logic          e_done;
        int            e_icnt;
    } vec_t;

    vec_t vecs [NV];

    fetch_unit #(.pc_width(PW), .instr_width(IW), .cnt_width(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .imem_addr   (imem_addr),
        .imem_en     (imem_en),
        .imem_data   (imem_data),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .done        (done),
        .instr_count (instr_count),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: content is the low 9 bits of the address; holds when disabled.
    always @(posedge clk) begin
        if (imem_en) imem_data <= imem_addr[IW-1:0];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic st, input int sa, input logic stl, input logic rd,
                                input int rpc, input logic hl, input logic ev, input int ei,
                                input int ep, input logic een, input logic ca, input int ea,
                                input logic ed, input int eic);
        vec_t v;
        v.st = st; v.sa = sa[PW-1:0]; v.stl = stl; v.rd = rd; v.rpc = rpc[PW-1:0]; v.hl = hl;
        v.e_valid = ev; v.e_instr = ei[IW-1:0]; v.e_pc = ep[PW-1:0]; v.e_en = een;
        v.chk_addr = ca; v.e_addr = ea[PW-1:0]; v.e_done = ed; v.e_icnt = eic;
        return v;
    endfunction

    initial begin
        //            st  sa     stl rd rpc    hl  ev ei     ep     en ca addr   dn icnt
        vecs[0]  = mk(1, 'h010, 0, 0, 0,     0,  0, 0,     0,     0, 1, 'h000, 0, 0);
        vecs[1]  = mk(0, 0,     0, 0, 0,     0,  0, 0,     0,     1, 1, 'h010, 0, 0);
        vecs[2]  = mk(0, 0,     0, 0, 0,     0,  1, 'h010, 'h010, 1, 1, 'h011, 0, 0);
        vecs[3]  = mk(0, 0,     0, 0, 0,     0,  1, 'h011, 'h011, 1, 1, 'h012, 0, 1);
        vecs[4]  = mk(0, 0,     0, 1, 'h100, 0,  1, 'h012, 'h012, 1, 1, 'h013, 0, 2);
        vecs[5]  = mk(0, 0,     0, 0, 0,     1,  0, 0,     0,     1, 1, 'h100, 0, 3);
        vecs[6]  = mk(0, 0,     0, 0, 0,     0,  1, 'h100, 'h100, 1, 1, 'h101, 0, 3);
        vecs[7]  = mk(0, 0,     0, 1, 'h004, 0,  1, 'h101, 'h101, 1, 1, 'h102, 0, 4);
        vecs[8]  = mk(0, 0,     0, 0, 0,     0,  0, 0,     0,     1, 1, 'h004, 0, 5);
        vecs[9]  = mk(0, 0,     0, 0, 0,     0,  1, 'h004, 'h004, 1, 1, 'h005, 0, 5);
        vecs[10] = mk(0, 0,     1, 0, 0,     0,  1, 'h005, 'h005, 0, 1, 'h006, 0, 6);
        vecs[11] = mk(0, 0,     1, 1, 'h200, 0,  1, 'h005, 'h005, 0, 1, 'h006, 0, 6);
        vecs[12] = mk(0, 0,     1, 0, 0,     0,  1, 'h005, 'h005, 0, 1, 'h006, 0, 6);
        vecs[13] = mk(0, 0,     0, 0, 0,     0,  1, 'h005, 'h005, 1, 1, 'h006, 0, 6);
        vecs[14] = mk(0, 0,     0, 0, 0,     1,  1, 'h006, 'h006, 1, 1, 'h007, 0, 7);
        vecs[15] = mk(1, 'h3FE, 0, 0, 0,     0,  0, 0,     0,     0, 0, 0,     1, 8);
        vecs[16] = mk(0, 0,     0, 0, 0,     0,  0, 0,     0,     1, 1, 'h3FE, 0, 0);
        vecs[17] = mk(0, 0,     0, 0, 0,     0,  1, 'h1FE, 'h3FE, 1, 1, 'h3FF, 0, 0);
        vecs[18] = mk(0, 0,     0, 0, 0,     0,  1, 'h1FF, 'h3FF, 1, 1, 'h000, 0, 1);
        vecs[19] = mk(0, 0,     0, 0, 0,     1,  1, 'h000, 'h000, 1, 1, 'h001, 0, 2);
        vecs[20] = mk(0, 0,     0, 0, 0,     0,  0, 0,     0,     0, 0, 0,     1, 3);

        rst_n = 1'b0; start = 1'b0; start_addr = '0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(instr_valid), 0);
        chk("rst_en",    int'(imem_en), 0);
        chk("rst_addr",  int'(imem_addr), 0);
        chk("rst_pc",    int'(instr_pc), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_icnt",  int'(instr_count), 0);
        chk("rst_ccnt",  int'(cycle_count), 0);
        rst_n = 1'b1;

        // Table: start, steady stream, redirect bubble, stall, halt, wrap, halt.
        for (int i = 0; i < NV; i++) begin
            start = vecs[i].st; start_addr = vecs[i].sa; stall = vecs[i].stl;
            redirect = vecs[i].rd; redirect_pc = vecs[i].rpc; halt = vecs[i].hl;
            #1;
            chk($sformatf("v%0d_valid", i), int'(instr_valid), int'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_instr", i), int'(instruction), int'(vecs[i].e_instr));
                chk($sformatf("v%0d_pc", i), int'(instr_pc), int'(vecs[i].e_pc));
            end
            chk($sformatf("v%0d_en", i), int'(imem_en), int'(vecs[i].e_en));
            if (vecs[i].chk_addr)
                chk($sformatf("v%0d_addr", i), int'(imem_addr), int'(vecs[i].e_addr));
            chk($sformatf("v%0d_done", i), int'(done), int'(vecs[i].e_done));
            chk($sformatf("v%0d_icnt", i), int'(instr_count), vecs[i].e_icnt);
            step();
        end
        start = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
        #1;
        chk("wrap_ccnt", int'(cycle_count), 4);

        // Halt and redirect together: halt wins, redirect target never fetched.
        start = 1'b1; start_addr = 'h040;
        step();
        start = 1'b0;
        step();
        halt = 1'b1; redirect = 1'b1; redirect_pc = 'h100;
        #1;
        chk("hr_valid", int'(instr_valid), 1);
        chk("hr_instr", int'(instruction), 'h040);
        step();
        halt = 1'b0; redirect = 1'b0;
        #1;
        chk("hr_done",  int'(done), 1);
        chk("hr_en",    int'(imem_en), 0);
        chk("hr_valid2", int'(instr_valid), 0);
        chk("hr_icnt",  int'(instr_count), 1);
        step();
        chk("hr_en2",   int'(imem_en), 0);
        chk("hr_done2", int'(done), 1);
        start = 1'b1; start_addr = 'h020;
        step();
        start = 1'b0;
        #1;
        chk("rs_icnt", int'(instr_count), 0);
        chk("rs_ccnt", int'(cycle_count), 0);
        chk("rs_addr", int'(imem_addr), 'h020);
        chk("rs_en",   int'(imem_en), 1);
        chk("rs_done", int'(done), 0);
        step();
        chk("rs_valid", int'(instr_valid), 1);
        chk("rs_instr", int'(instruction), 'h020);
        chk("rs_pc",    int'(instr_pc), 'h020);

        // Asynchronous reset in the middle of a cycle while running.
        step();
        #2;
        rst_n = 1'b0; start = 1'b1;
        #1;
        chk("ar_valid", int'(instr_valid), 0);
        chk("ar_en",    int'(imem_en), 0);
        chk("ar_addr",  int'(imem_addr), 0);
        chk("ar_pc",    int'(instr_pc), 0);
        chk("ar_done",  int'(done), 0);
        chk("ar_icnt",  int'(instr_count), 0);
        chk("ar_ccnt",  int'(cycle_count), 0);
        step();
        start = 1'b0; rst_n = 1'b1;
        step();
        step();
        chk("ar_idle_en",    int'(imem_en), 0);
        chk("ar_idle_valid", int'(instr_valid), 0);
        chk("ar_idle_done",  int'(done), 0);

        // Long run: both counters saturate at all-ones.
        start = 1'b1; start_addr = 'h000;
        step();
        start = 1'b0;
        repeat (80) step();
        chk("sat_ccnt", int'(cycle_count), (1 << CW) - 1);
        chk("sat_icnt", int'(instr_count), (1 << CW) - 1);
        chk("sat_valid", int'(instr_valid), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_unit
